// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 read-side controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EHIGH,
        HOLD,
        GAP
    } lcd_state_t;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam int DEF_T_AS      = 4;
    localparam int DEF_T_PW      = 16;
    localparam int DEF_T_H       = 4;
    localparam int DEF_T_GAP     = 8;
    localparam int DEF_MAX_POLLS = 200;

    localparam int BF_BIT = 7;

endpackage

// File: rtl/lcd_phase_timer.sv
// 8-bit loadable down-counter shared by all bus phases; done marks the last cycle of a phase.
module lcd_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       done
);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != 8'd0) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign done = (count_reg == 8'd1);

endmodule

// File: rtl/lcd_reader.sv
// Read-side controller for an HD44780 16x2 LCD: single RW=1 reads of busy/address or data.
// Define LCD_READER_POLL_EN to add the busy-flag poll sequencer (iPOLL, oTIMEOUT, MAX_POLLS).
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_AS  = DEF_T_AS,
    parameter int T_PW  = DEF_T_PW,
    parameter int T_H   = DEF_T_H,
    parameter int T_GAP = DEF_T_GAP
`ifdef LCD_READER_POLL_EN
    ,
    parameter int MAX_POLLS = DEF_MAX_POLLS
`endif
) (
`ifdef LCD_READER_POLL_EN
    input  logic       iPOLL,
    output logic       oTIMEOUT,
`endif
    input  logic       iCLK_50MHZ,
    input  logic       iRST_N,
    input  logic       iREQ,
    input  logic       iRS,
    output logic       oREADY,
    output logic       oVALID,
    output logic [7:0] oDATA,
    output logic       oBF,
    output logic [6:0] oADDR,
    output logic       oBUS_OWN,
    inout  wire  [7:0] DATA_BUS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic       LCD_RS
);

    lcd_state_t state_reg;
    logic       ready_reg, valid_reg, bf_reg, own_reg, rw_reg, e_reg, rs_reg;
    logic [7:0] data_reg;
    logic [6:0] addr_reg;

    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_done;

`ifdef LCD_READER_POLL_EN
    logic        polling_reg;
    logic        timeout_reg;
    logic [15:0] poll_cnt_reg;
    logic        start_poll;
    logic        poll_last;

    assign start_poll = (state_reg == IDLE) && !iREQ && iPOLL;
    // A poll ends on the first idle read or when the read budget is spent.
    assign poll_last  = !DATA_BUS[BF_BIT] || (poll_cnt_reg == 16'(MAX_POLLS));
`endif

    lcd_phase_timer u_timer (
        .clk        (iCLK_50MHZ),
        .rst_n      (iRST_N),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_comb begin
        timer_load  = 1'b0;
        timer_value = 8'd0;
        case (state_reg)
            IDLE: begin
`ifdef LCD_READER_POLL_EN
                if (iREQ || start_poll) begin
`else
                if (iREQ) begin
`endif
                    timer_load  = 1'b1;
                    timer_value = 8'(T_AS);
                end
            end
            SETUP: begin
                timer_load  = timer_done;
                timer_value = 8'(T_PW);
            end
            EHIGH: begin
                timer_load  = timer_done;
                timer_value = 8'(T_H);
            end
            HOLD: begin
                timer_load  = timer_done;
                timer_value = 8'(T_GAP);
            end
            GAP: begin
`ifdef LCD_READER_POLL_EN
                timer_load  = timer_done && polling_reg;
                timer_value = 8'(T_AS);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            data_reg  <= 8'd0;
            bf_reg    <= 1'b0;
            addr_reg  <= 7'd0;
            own_reg   <= 1'b0;
            rw_reg    <= 1'b0;
            e_reg     <= 1'b0;
            rs_reg    <= RS_CMD;
`ifdef LCD_READER_POLL_EN
            polling_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            poll_cnt_reg <= 16'd0;
`endif
        end else begin
            valid_reg <= 1'b0;
`ifdef LCD_READER_POLL_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (iREQ) begin
                        rs_reg    <= iRS;
                        rw_reg    <= 1'b1;
                        own_reg   <= 1'b1;
                        ready_reg <= 1'b0;
                        state_reg <= SETUP;
`ifdef LCD_READER_POLL_EN
                    end else if (iPOLL) begin
                        rs_reg       <= RS_CMD;
                        rw_reg       <= 1'b1;
                        own_reg      <= 1'b1;
                        ready_reg    <= 1'b0;
                        polling_reg  <= 1'b1;
                        poll_cnt_reg <= 16'd1;
                        state_reg    <= SETUP;
`endif
                    end
                end
                SETUP: begin
                    if (timer_done) begin
                        e_reg     <= 1'b1;
                        state_reg <= EHIGH;
                    end
                end
                EHIGH: begin
                    if (timer_done) begin
                        e_reg    <= 1'b0;
                        data_reg <= DATA_BUS;
                        if (rs_reg == RS_CMD) begin
                            bf_reg   <= DATA_BUS[BF_BIT];
                            addr_reg <= DATA_BUS[BF_BIT-1:0];
                        end
`ifdef LCD_READER_POLL_EN
                        if (polling_reg) begin
                            valid_reg   <= poll_last;
                            timeout_reg <= DATA_BUS[BF_BIT] && poll_last;
                            polling_reg <= !poll_last;
                        end else begin
                            valid_reg <= 1'b1;
                        end
`else
                        valid_reg <= 1'b1;
`endif
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (timer_done) begin
                        rw_reg    <= 1'b0;
                        own_reg   <= 1'b0;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (timer_done) begin
`ifdef LCD_READER_POLL_EN
                        if (polling_reg) begin
                            rw_reg       <= 1'b1;
                            own_reg      <= 1'b1;
                            poll_cnt_reg <= poll_cnt_reg + 16'd1;
                            state_reg    <= SETUP;
                        end else begin
                            ready_reg <= 1'b1;
                            state_reg <= IDLE;
                        end
`else
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign oREADY   = ready_reg;
    assign oVALID   = valid_reg;
    assign oDATA    = data_reg;
    assign oBF      = bf_reg;
    assign oADDR    = addr_reg;
    assign oBUS_OWN = own_reg;
    assign LCD_RW   = rw_reg;
    assign LCD_E    = e_reg;
    assign LCD_RS   = rs_reg;
`ifdef LCD_READER_POLL_EN
    assign oTIMEOUT = timeout_reg;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader (default build): table of single reads plus multi-cycle corner sequences.
module tb_lcd_reader;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       rs_in;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       bf;
    logic [6:0] addr;
    logic       bus_own;
    logic       lcd_rw;
    logic       lcd_e;
    logic       lcd_rs;
    logic [7:0] bus_drv;
    wire  [7:0] data_bus;

    assign data_bus = bus_drv;

    lcd_reader dut (
        .iCLK_50MHZ (clk),
        .iRST_N     (rst_n),
        .iREQ       (req),
        .iRS        (rs_in),
        .oREADY     (ready),
        .oVALID     (valid),
        .oDATA      (data),
        .oBF        (bf),
        .oADDR      (addr),
        .oBUS_OWN   (bus_own),
        .DATA_BUS   (data_bus),
        .LCD_RW     (lcd_rw),
        .LCD_E      (lcd_e),
        .LCD_RS     (lcd_rs)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] bus;
        logic [7:0] exp_data;
        logic       exp_bf;
        logic [6:0] exp_addr;
    } vec_t;

    vec_t vecs [0:5];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},  32'(ready),   32'(1));
        check({tag, "_valid"},  32'(valid),   32'(0));
        check({tag, "_data"},   32'(data),    32'(0));
        check({tag, "_bf"},     32'(bf),      32'(0));
        check({tag, "_addr"},   32'(addr),    32'(0));
        check({tag, "_own"},    32'(bus_own), 32'(0));
        check({tag, "_rw"},     32'(lcd_rw),  32'(0));
        check({tag, "_e"},      32'(lcd_e),   32'(0));
        check({tag, "_rs"},     32'(lcd_rs),  32'(0));
    endtask

    // One read transaction, cycle-numbered from the accepting edge (edge 0 -> cycle 1).
    task automatic run_txn(input string tag, input logic rs, input logic [7:0] bus,
                           input logic [7:0] exp_data, input logic exp_bf,
                           input logic [6:0] exp_addr, input bit pulses);
        int rw_cnt = 0, own_cnt = 0, e_cnt = 0, e_first = 0;
        int v_cnt = 0, v_cyc = 0, rdy_cyc = 0, rs_bad = 0;
        logic [7:0] v_data = 8'h00;
        logic       v_bf = 1'b0;
        logic [6:0] v_addr = 7'h00;
        for (int w = 0; w < 100 && !ready; w++) tick();
        check({tag, "_ready_in"}, 32'(ready), 32'(1));
        req     = 1'b1;
        rs_in   = rs;
        bus_drv = ~bus;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 2)  rs_in = ~rs;
            if (c == 5)  bus_drv = bus;
            if (c == 21) bus_drv = ~bus;
            if (pulses)  req = (c == 5 || c == 30);
            if (lcd_rw)  rw_cnt++;
            if (bus_own) own_cnt++;
            if (lcd_rw && lcd_rs !== rs) rs_bad++;
            if (lcd_e) begin
                e_cnt++;
                if (e_first == 0) e_first = c;
            end
            if (ready && rdy_cyc == 0) rdy_cyc = c;
            if (valid) begin
                v_cnt++;
                v_cyc  = c;
                v_data = data;
                v_bf   = bf;
                v_addr = addr;
            end
            if (c < 33) tick();
        end
        req = 1'b0;
        check({tag, "_rw_cycles"},  32'(rw_cnt),  32'(24));
        check({tag, "_own_cycles"}, 32'(own_cnt), 32'(24));
        check({tag, "_rs_stable"},  32'(rs_bad),  32'(0));
        check({tag, "_e_first"},    32'(e_first), 32'(5));
        check({tag, "_e_cycles"},   32'(e_cnt),   32'(16));
        check({tag, "_valid_cnt"},  32'(v_cnt),   32'(1));
        check({tag, "_valid_cyc"},  32'(v_cyc),   32'(21));
        check({tag, "_ready_cyc"},  32'(rdy_cyc), 32'(33));
        check({tag, "_data"},       32'(v_data),  32'(exp_data));
        check({tag, "_bf"},         32'(v_bf),    32'(exp_bf));
        check({tag, "_addr"},       32'(v_addr),  32'(exp_addr));
        $display("txn %s rs=%0d bus=%02h -> data=%02h bf=%0d addr=%02h valid@%0d ready@%0d",
                 tag, rs, bus, v_data, v_bf, v_addr, v_cyc, rdy_cyc);
        check({tag, "_data_hold"},  32'(data),    32'(exp_data));
    endtask

    initial begin
        int v_cnt, v1, v2, v3, low_run, gap_min, gaps;
        logic e_prev;
        bit   seen_high;

        vecs[0] = '{1'b0, 8'h85, 8'h85, 1'b1, 7'h05};
        vecs[1] = '{1'b1, 8'h41, 8'h41, 1'b1, 7'h05};
        vecs[2] = '{1'b0, 8'h02, 8'h02, 1'b0, 7'h02};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 7'h02};
        vecs[4] = '{1'b0, 8'h7F, 8'h7F, 1'b0, 7'h7F};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 1'b1, 7'h00};

        rst_n   = 1'b0;
        req     = 1'b0;
        rs_in   = 1'b0;
        bus_drv = 8'h00;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].rs, vecs[i].bus,
                    vecs[i].exp_data, vecs[i].exp_bf, vecs[i].exp_addr, 1'b0);
        end

        // Requests mid-transaction must be dropped, not queued.
        run_txn("ignored_req", 1'b1, 8'h3C, 8'h3C, 1'b1, 7'h00, 1'b1);

        // Held request: three back-to-back reads.
        v_cnt = 0; v1 = 0; v2 = 0; v3 = 0;
        low_run = 0; gap_min = 1000; gaps = 0; seen_high = 0; e_prev = 1'b0;
        rs_in   = 1'b0;
        bus_drv = 8'hA5;
        req     = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c == 67) req = 1'b0;
            if (valid) begin
                v_cnt++;
                if (v_cnt == 1) v1 = c;
                if (v_cnt == 2) v2 = c;
                if (v_cnt == 3) v3 = c;
            end
            if (lcd_e) begin
                if (!e_prev && seen_high) begin
                    gaps++;
                    if (low_run < gap_min) gap_min = low_run;
                end
                seen_high = 1;
                low_run   = 0;
            end else begin
                low_run++;
            end
            e_prev = lcd_e;
        end
        req = 1'b0;
        $display("txn held_req valids=%0d at %0d,%0d,%0d min_e_gap=%0d", v_cnt, v1, v2, v3, gap_min);
        check("held_valid_cnt", 32'(v_cnt),      32'(3));
        check("held_first",     32'(v1),         32'(21));
        check("held_space12",   32'(v2 - v1),    32'(33));
        check("held_space23",   32'(v3 - v2),    32'(33));
        check("held_gaps",      32'(gaps),       32'(2));
        check("held_gap_min",   32'(gap_min >= 12), 32'(1));
        check("held_data",      32'(data),       32'(8'hA5));
        check("held_bf",        32'(bf),         32'(1));
        check("held_addr",      32'(addr),       32'(7'h25));

        // Reset during EHIGH: E drops at once, nothing is reported.
        for (int w = 0; w < 100 && !ready; w++) tick();
        rs_in   = 1'b1;
        bus_drv = 8'h11;
        req     = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("rst_mid_e_before", 32'(lcd_e), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        $display("txn reset_mid e=%0d rw=%0d own=%0d ready=%0d", lcd_e, lcd_rw, bus_own, ready);
        tick();
        tick();
        rst_n = 1'b1;
        v_cnt = 0; gaps = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (valid) v_cnt++;
            if (lcd_e || !ready) gaps++;
        end
        check("rst_mid_no_valid", 32'(v_cnt), 32'(0));
        check("rst_mid_idle",     32'(gaps),  32'(0));
        check("rst_mid_data",     32'(data),  32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side controller for the HD44780-compatible 16x2 character LCD. It is the counterpart of the existing LCD write/display path.
- It performs single read transactions on the LCD bus (RW=1):
  - RS=0 returns the busy flag and address counter.
  - RS=1 returns a DDRAM/CGRAM data byte.
- The top level gives it bus ownership between write transactions. It is used to poll the busy flag instead of relying on fixed delays, and to read back displayed characters for self-test.

Parameters:
- T_AS, 4, cycles of RS/RW setup before E rises (80 ns at 50 MHz; minimum 40 ns).
- T_PW, 16, cycles E held high (320 ns; minimum 230 ns).
- T_H, 4, cycles RS/RW held after E falls.
- T_GAP, 8, idle cycles before the next request is accepted (keeps E cycle time ≥ 500 ns).
- All timing parameters must be in 1..255; the phase counter is 8 bits.

Ports:
- iCLK_50MHZ  in  1  system clock, 50 MHz.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ  in  1  read request; sampled only while oREADY=1.
- iRS  in  1  register select for the request: 0 = busy/address, 1 = data.
- oREADY  out  1  block idle and able to accept iREQ.
- oVALID  out  1  one-cycle strobe; oDATA, oBF and oADDR are valid.
- oDATA  out  8  raw byte read from the bus.
- oBF  out  1  busy flag, which is DATA_BUS[7] of an RS=0 read.
- oADDR  out  7  address counter, which is DATA_BUS[6:0] of an RS=0 read.
- oBUS_OWN  out  1  high from SETUP through HOLD; the top level muxes LCD_RW, LCD_E and LCD_RS from this block when high.
- DATA_BUS  inout  8  LCD data bus; this block never drives it (always high-Z).
- LCD_RW  out  1  1 during a transaction, otherwise 0.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  latched register select.

Behaviour:
- Single clock domain; reset is asynchronous and active-low. All outputs are registered.
- Reset values:
  - oREADY=1, oVALID=0, oDATA=0, oBF=0, oADDR=0, oBUS_OWN=0.
  - LCD_RW=0, LCD_E=0, LCD_RS=0.
  - FSM in IDLE, counter 0.
- FSM states and transitions:
  - IDLE: oREADY=1. When iREQ=1, latch iRS into LCD_RS, set LCD_RW=1 and oBUS_OWN=1, clear oREADY, load the counter with T_AS, then go to SETUP.
  - SETUP: LCD_E=0. When the counter reaches 1, set LCD_E=1, load T_PW, then go to EHIGH.
  - EHIGH: LCD_E=1. On the edge where the counter reaches 1:
    - capture DATA_BUS into the data register;
    - clear LCD_E;
    - assert oVALID for exactly one cycle (the first HOLD cycle);
    - load T_H and go to HOLD.
  - HOLD: LCD_RW and LCD_RS stay stable. At the end of the phase, clear LCD_RW and oBUS_OWN, load T_GAP, then go to GAP.
  - GAP: at the end of the phase, set oREADY=1 and return to IDLE.
- Latency with default parameters:
  - Request accepted at edge 0.
  - LCD_E rises after 4 cycles and stays high for 16 cycles.
  - oVALID is high in cycle 21.
  - oREADY is high again in cycle 33.
- oDATA, oBF and oADDR keep their values until the next capture. oBF and oADDR are updated only by RS=0 reads; oDATA is updated by every read.
- iREQ while oREADY=0 is ignored; there is no queue, so the requester must re-assert.
- iREQ held continuously produces back-to-back transactions, each separated by the GAP phase.
- Reset asserted mid-transaction:
  - LCD_E drops immediately (asynchronously) and the bus is released.
  - The captured data is discarded and oVALID is not asserted.
- iRS changes after acceptance have no effect on the transaction in progress.

Optional Feature:
- Macro: LCD_READER_POLL_EN.
- Defined:
  - Adds input port iPOLL, output port oTIMEOUT and parameter MAX_POLLS (default 200).
  - iPOLL=1 in IDLE starts a poll sequence: repeated RS=0 reads, each taking the full SETUP→GAP timing, until BF=0 is read.
  - oVALID is asserted only for the final read, the one with BF=0.
  - If MAX_POLLS reads all return BF=1, the sequence stops and oTIMEOUT pulses for one cycle together with oVALID, carrying the last data.
  - iREQ has priority over iPOLL when both are asserted in the same cycle.
- Undefined: the ports, the parameter and the poll logic are absent; the block behaves exactly as in Behaviour.

Decomposition:
- Shared package lcd_pkg holds:
  - the FSM state enum (IDLE, SETUP, EHIGH, HOLD, GAP);
  - RS encodings (RS_CMD=0, RS_DATA=1);
  - the default timing constants;
  - the BF bit index (7).
- One sub-module: lcd_phase_timer. It is an 8-bit loadable down-counter with load, value and done (done when the count is 1). It is instantiated once and shared by all phases.

Test Plan:
- Reset, then a single iREQ with iRS=0, with a bus model returning 8'h85:
  - LCD_RW=1 and LCD_RS=0 for 24 cycles;
  - LCD_E high for exactly 16 cycles, starting 4 cycles after acceptance;
  - oVALID strobes once with oBF=1, oADDR=7'h05, oDATA=8'h85.
- iREQ with iRS=1 and bus 8'h41 → LCD_RS=1 throughout; oDATA=8'h41; oBF and oADDR keep their previous values.
- iREQ pulsed in cycles 5 and 30 of an active transaction → ignored; exactly one oVALID; oREADY is high again in cycle 33.
- iREQ held high for 3 transactions → 3 oVALID strobes spaced 33 cycles apart; each E low gap ≥ 12 cycles.
- iRST_N asserted in cycle 10 (during EHIGH) → LCD_E=0 immediately; all outputs at reset values; no oVALID.
- With LCD_READER_POLL_EN defined and a bus returning BF=1 three times then 8'h02 → 4 reads; a single oVALID with oADDR=7'h02; oTIMEOUT stays 0. With MAX_POLLS=5 and BF stuck at 1 → 5 reads, then oTIMEOUT and oVALID pulse together.
